// File: rtl/ddr3_byte_bridge.sv
// ddr3_byte_bridge
//   Memory-side responder for the slot subsystem's byte-wide ddr3_* port.
//   Each byte read or write becomes one single-beat 64-bit Avalon-MM access
//   on the DDRAM port. A one-line (8-byte) write-through read cache lets
//   sequential byte reads inside the same 64-bit word finish without DDR3.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ddr3_addr[27:0]   byte address from the initiator
//   ddr3_rd/ddr3_wr   read/write strobes, sampled only while ddr3_ready=1
//   ddr3_din[7:0]     write data
//   ddr3_dout[7:0]    read data (registered)
//   ddr3_ready        1 = idle / previous access complete
//   ddr3_request      initiator owns DDR3; 0 = strobes ignored, cache dropped
//   DDRAM_*           single-beat Avalon-MM master (BUSY = waitrequest)
//
// Handshake
//   Initiator side: an access is accepted on an edge where ddr3_ready=1,
//   ddr3_request=1 and a strobe is high. Strobes seen while ddr3_ready=0 are
//   dropped, not queued. Avalon side: DDRAM_RD/DDRAM_WE and their address,
//   data and byte enables stay stable until an edge with DDRAM_BUSY=0.
//   DDRAM_DOUT_READY is only honoured in RD_WAIT.

module ddr3_byte_bridge #(
    parameter logic [28:0] BASE_ADDR = 29'h0600_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] ddr3_addr,
    input  logic        ddr3_rd,
    input  logic        ddr3_wr,
    input  logic [7:0]  ddr3_din,
    output logic [7:0]  ddr3_dout,
    output logic        ddr3_ready,
    input  logic        ddr3_request,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic        DDRAM_RD,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t      state;

    // Cache line: one 64-bit word, tagged with its byte-address bits [27:3].
    logic [63:0] line;
    logic [24:0] tag;
    logic        valid;

    // Request fields latched at accept, used when the read data returns.
    logic [24:0] pend_tag;
    logic [2:0]  pend_sel;

    logic        hit;
    logic [28:0] word_addr;

    assign DDRAM_BURSTCNT = 8'd1;
    assign hit            = valid && (tag == ddr3_addr[27:3]);
    // 29-bit add: wraps modulo 2^29 by construction.
    assign word_addr      = BASE_ADDR + {4'b0000, ddr3_addr[27:3]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ddr3_ready <= 1'b1;
            ddr3_dout  <= 8'hFF;
            DDRAM_RD   <= 1'b0;
            DDRAM_WE   <= 1'b0;
            DDRAM_BE   <= 8'h00;
            DDRAM_ADDR <= 29'h0;
            DDRAM_DIN  <= 64'h0;
            line       <= 64'h0;
            tag        <= 25'h0;
            valid      <= 1'b0;
            pend_tag   <= 25'h0;
            pend_sel   <= 3'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ddr3_request && (ddr3_rd || ddr3_wr)) begin
                        if (ddr3_wr) begin
                            // Write wins over a simultaneous read.
                            ddr3_ready <= 1'b0;
                            DDRAM_WE   <= 1'b1;
                            DDRAM_ADDR <= word_addr;
                            DDRAM_DIN  <= {8{ddr3_din}};
                            DDRAM_BE   <= 8'b1 << ddr3_addr[2:0];
                            if (hit) begin
                                line[{ddr3_addr[2:0], 3'b000} +: 8] <= ddr3_din;
                            end
                            state      <= WR_REQ;
                        end else if (hit) begin
                            // Zero-wait hit: ready never drops.
                            ddr3_dout <= line[{ddr3_addr[2:0], 3'b000} +: 8];
                        end else begin
                            ddr3_ready <= 1'b0;
                            DDRAM_RD   <= 1'b1;
                            DDRAM_ADDR <= word_addr;
                            pend_tag   <= ddr3_addr[27:3];
                            pend_sel   <= ddr3_addr[2:0];
                            state      <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        line       <= DDRAM_DOUT;
                        tag        <= pend_tag;
                        valid      <= 1'b1;
                        ddr3_dout  <= DDRAM_DOUT[{pend_sel, 3'b000} +: 8];
                        ddr3_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE   <= 1'b0;
                        DDRAM_BE   <= 8'h00;
                        ddr3_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Losing ownership invalidates the line; placed last so it also
            // overrides a fill completing in the same cycle.
            if (!ddr3_request) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_byte_bridge.sv
// tb_ddr3_byte_bridge
//   Self-checking bench for ddr3_byte_bridge. A second instance with
//   BASE_ADDR=29'h1FFF_FFFF shares all inputs to exercise address wrap.
//   A bench-side memory model and cache-tag model supply expected read
//   bytes, which are queued in exp_q when a read is issued and popped
//   when the DUT returns data.

module tb_ddr3_byte_bridge;

    localparam logic [28:0] BASE      = 29'h0600_0000;
    localparam logic [28:0] WRAP_BASE = 29'h1FFF_FFFF;

    logic        clk;
    logic        reset;
    logic [27:0] ddr3_addr;
    logic        ddr3_rd;
    logic        ddr3_wr;
    logic [7:0]  ddr3_din;
    logic [7:0]  ddr3_dout;
    logic        ddr3_ready;
    logic        ddr3_request;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    logic [7:0]  w_dout;
    logic        w_ready;
    logic [7:0]  w_burstcnt;
    logic [28:0] w_addr;
    logic        w_rd;
    logic [63:0] w_din;
    logic [7:0]  w_be;
    logic        w_we;

    int checks = 0;
    int fails  = 0;

    logic [7:0]  exp_q[$];
    logic [63:0] mem[logic [24:0]];
    logic        m_valid;
    logic [24:0] m_tag;

    ddr3_byte_bridge #(.BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset),
        .ddr3_addr(ddr3_addr), .ddr3_rd(ddr3_rd), .ddr3_wr(ddr3_wr),
        .ddr3_din(ddr3_din), .ddr3_dout(ddr3_dout), .ddr3_ready(ddr3_ready),
        .ddr3_request(ddr3_request),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    ddr3_byte_bridge #(.BASE_ADDR(WRAP_BASE)) u_wrap (
        .clk(clk), .reset(reset),
        .ddr3_addr(ddr3_addr), .ddr3_rd(ddr3_rd), .ddr3_wr(ddr3_wr),
        .ddr3_din(ddr3_din), .ddr3_dout(w_dout), .ddr3_ready(w_ready),
        .ddr3_request(ddr3_request),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(w_burstcnt),
        .DDRAM_ADDR(w_addr), .DDRAM_RD(w_rd),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_DIN(w_din), .DDRAM_BE(w_be), .DDRAM_WE(w_we)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read one byte; the model decides hit or miss, and on a miss the bench
    // plays the DDR3 side with the given waitrequest and data latency.
    task automatic bus_read(input logic [27:0] a, input int busy, input int lat);
        logic [24:0] idx;
        logic        hit;
        logic [63:0] word;
        logic [28:0] exp_addr;
        logic [28:0] exp_waddr;
        logic [7:0]  got;
        idx = a[27:3];
        hit = m_valid && (m_tag == idx);
        if (!mem.exists(idx)) mem[idx] = {$urandom(), $urandom()};
        word = mem[idx];
        exp_q.push_back(word[{a[2:0], 3'b000} +: 8]);
        exp_addr  = BASE + {4'b0000, idx};
        exp_waddr = WRAP_BASE + {4'b0000, idx};
        ddr3_addr  = a;
        ddr3_rd    = 1'b1;
        DDRAM_BUSY = (busy > 0);
        @(posedge clk); #1;
        ddr3_rd = 1'b0;
        if (hit) begin
            checks++;
            if (DDRAM_RD !== 1'b0 || ddr3_ready !== 1'b1) begin
                fails++;
                $display("FAIL hit_no_rd a=%h: rd=%b ready=%b, need rd=0 ready=1", a, DDRAM_RD, ddr3_ready);
            end
            got = exp_q.pop_front();
            checks++;
            if (ddr3_dout !== got) begin
                fails++;
                $display("FAIL hit_data a=%h: got %h, need %h", a, ddr3_dout, got);
            end
        end else begin
            checks++;
            if (DDRAM_RD !== 1'b1 || ddr3_ready !== 1'b0 || DDRAM_ADDR !== exp_addr || DDRAM_BURSTCNT !== 8'd1) begin
                fails++;
                $display("FAIL miss_issue a=%h: rd=%b ready=%b addr=%h bc=%h, need rd=1 ready=0 addr=%h bc=01",
                         a, DDRAM_RD, ddr3_ready, DDRAM_ADDR, DDRAM_BURSTCNT, exp_addr);
            end
            checks++;
            if (w_addr !== exp_waddr) begin
                fails++;
                $display("FAIL wrap_addr a=%h: got %h, need %h", a, w_addr, exp_waddr);
            end
            for (int i = 0; i < busy; i++) begin
                @(posedge clk); #1;
                checks++;
                if (DDRAM_RD !== 1'b1 || DDRAM_ADDR !== exp_addr) begin
                    fails++;
                    $display("FAIL rd_hold a=%h cyc=%0d: rd=%b addr=%h, need rd=1 addr=%h", a, i, DDRAM_RD, DDRAM_ADDR, exp_addr);
                end
            end
            DDRAM_BUSY = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (DDRAM_RD !== 1'b0 || ddr3_ready !== 1'b0) begin
                fails++;
                $display("FAIL rd_release a=%h: rd=%b ready=%b, need rd=0 ready=0", a, DDRAM_RD, ddr3_ready);
            end
            for (int i = 0; i < lat; i++) begin
                // A write strobe while not ready must be dropped.
                ddr3_wr = (i == 0);
                @(posedge clk); #1;
                ddr3_wr = 1'b0;
                checks++;
                if (ddr3_ready !== 1'b0 || DDRAM_WE !== 1'b0) begin
                    fails++;
                    $display("FAIL wait_ignore a=%h cyc=%0d: ready=%b we=%b, need 0 0", a, i, ddr3_ready, DDRAM_WE);
                end
            end
            DDRAM_DOUT       = word;
            DDRAM_DOUT_READY = 1'b1;
            @(posedge clk); #1;
            DDRAM_DOUT_READY = 1'b0;
            DDRAM_DOUT       = {$urandom(), $urandom()};
            got = exp_q.pop_front();
            checks++;
            if (ddr3_ready !== 1'b1 || ddr3_dout !== got) begin
                fails++;
                $display("FAIL miss_data a=%h: ready=%b dout=%h, need ready=1 dout=%h", a, ddr3_ready, ddr3_dout, got);
            end
            if (ddr3_request) begin
                m_valid = 1'b1;
                m_tag   = idx;
            end
        end
    endtask

    // Write one byte (optionally with rd raised too); waitrequest held for busy edges.
    task automatic bus_write(input logic [27:0] a, input logic [7:0] d, input int busy, input bit with_rd);
        logic [24:0] idx;
        logic [63:0] word;
        logic [7:0]  exp_be;
        logic [28:0] exp_addr;
        int          we_cycles;
        idx = a[27:3];
        if (!mem.exists(idx)) mem[idx] = {$urandom(), $urandom()};
        word = mem[idx];
        word[{a[2:0], 3'b000} +: 8] = d;
        mem[idx] = word;
        exp_be   = 8'b1 << a[2:0];
        exp_addr = BASE + {4'b0000, idx};
        ddr3_addr  = a;
        ddr3_din   = d;
        ddr3_wr    = 1'b1;
        ddr3_rd    = with_rd;
        DDRAM_BUSY = (busy > 0);
        @(posedge clk); #1;
        ddr3_wr = 1'b0;
        ddr3_rd = 1'b0;
        checks++;
        if (DDRAM_WE !== 1'b1 || DDRAM_RD !== 1'b0 || ddr3_ready !== 1'b0 || DDRAM_BE !== exp_be ||
            DDRAM_DIN !== {8{d}} || DDRAM_ADDR !== exp_addr) begin
            fails++;
            $display("FAIL wr_issue a=%h: we=%b rd=%b ready=%b be=%h din=%h addr=%h, need we=1 rd=0 ready=0 be=%h din=%h addr=%h",
                     a, DDRAM_WE, DDRAM_RD, ddr3_ready, DDRAM_BE, DDRAM_DIN, DDRAM_ADDR, exp_be, {8{d}}, exp_addr);
        end
        we_cycles = 1;
        for (int i = 0; i < busy; i++) begin
            @(posedge clk); #1;
            if (DDRAM_WE === 1'b1 && DDRAM_BE === exp_be && DDRAM_DIN === {8{d}}) we_cycles++;
        end
        DDRAM_BUSY = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (DDRAM_WE !== 1'b0 || DDRAM_BE !== 8'h00 || ddr3_ready !== 1'b1) begin
            fails++;
            $display("FAIL wr_done a=%h: we=%b be=%h ready=%b, need 0 00 1", a, DDRAM_WE, DDRAM_BE, ddr3_ready);
        end
        checks++;
        if (we_cycles != busy + 1) begin
            fails++;
            $display("FAIL we_held a=%h: held %0d cycles, need %0d", a, we_cycles, busy + 1);
        end
    endtask

    task automatic drop_request();
        ddr3_request = 1'b0;
        ddr3_addr    = 28'h0000012;
        ddr3_rd      = 1'b1;
        @(posedge clk); #1;
        ddr3_rd      = 1'b0;
        ddr3_request = 1'b1;
        m_valid      = 1'b0;
        checks++;
        if (DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0 || ddr3_ready !== 1'b1) begin
            fails++;
            $display("FAIL no_own_ignore: rd=%b we=%b ready=%b, need 0 0 1", DDRAM_RD, DDRAM_WE, ddr3_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        checks++;
        if (ddr3_ready !== 1'b1 || ddr3_dout !== 8'hFF || DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0 ||
            DDRAM_BE !== 8'h00 || DDRAM_BURSTCNT !== 8'd1) begin
            fails++;
            $display("FAIL reset_vals: ready=%b dout=%h rd=%b we=%b be=%h bc=%h, need 1 ff 0 0 00 01",
                     ddr3_ready, ddr3_dout, DDRAM_RD, DDRAM_WE, DDRAM_BE, DDRAM_BURSTCNT);
        end
        checks++;
        if (w_ready !== 1'b1 || w_dout !== 8'hFF || w_rd !== 1'b0 || w_we !== 1'b0 || w_be !== 8'h00 ||
            w_burstcnt !== 8'd1 || w_din !== 64'h0) begin
            fails++;
            $display("FAIL reset_wrap_vals: ready=%b dout=%h rd=%b we=%b be=%h", w_ready, w_dout, w_rd, w_we, w_be);
        end
    endtask

    task automatic test_read_miss();
        mem[25'h2] = 64'h8877665544332211;
        bus_read(28'h0000012, 0, 3);
        checks++;
        if (ddr3_dout !== 8'h33 || DDRAM_ADDR !== 29'h0600_0002) begin
            fails++;
            $display("FAIL t1_const: dout=%h addr=%h, need 33 06000002", ddr3_dout, DDRAM_ADDR);
        end
    endtask

    task automatic test_read_hit();
        bus_read(28'h0000017, 0, 0);
        checks++;
        if (ddr3_dout !== 8'h88) begin
            fails++;
            $display("FAIL t2_const: dout=%h, need 88", ddr3_dout);
        end
        for (int i = 0; i < 8; i++) bus_read(28'h0000010 + 28'(i), 0, 0);
    endtask

    task automatic test_write_through();
        bus_write(28'h0000011, 8'hAB, 3, 1'b0);
        bus_read(28'h0000011, 0, 0);
        checks++;
        if (ddr3_dout !== 8'hAB) begin
            fails++;
            $display("FAIL t3_const: dout=%h, need ab", ddr3_dout);
        end
    endtask

    task automatic test_ownership();
        drop_request();
        bus_read(28'h0000012, 1, 2);
        bus_write(28'h0000013, 8'h5A, 0, 1'b1);
        bus_read(28'h0000013, 0, 0);
        checks++;
        if (ddr3_dout !== 8'h5A) begin
            fails++;
            $display("FAIL t4_rdwr_data: dout=%h, need 5a", ddr3_dout);
        end
    endtask

    task automatic test_wrap();
        drop_request();
        bus_read(28'h0000008, 0, 1);
        checks++;
        if (w_addr !== 29'h0) begin
            fails++;
            $display("FAIL t5_wrap: addr=%h, need 00000000", w_addr);
        end
    endtask

    task automatic test_reset_mid();
        mem[25'h8] = 64'hF0E1D2C3B4A59687;
        ddr3_addr  = 28'h0000040;
        ddr3_rd    = 1'b1;
        DDRAM_BUSY = 1'b0;
        @(posedge clk); #1;
        ddr3_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        DDRAM_DOUT       = 64'hDEADBEEFCAFEF00D;
        DDRAM_DOUT_READY = 1'b1;
        @(posedge clk); #1;
        DDRAM_DOUT_READY = 1'b0;
        checks++;
        if (ddr3_ready !== 1'b1 || ddr3_dout !== 8'hFF || DDRAM_RD !== 1'b0) begin
            fails++;
            $display("FAIL late_dout_discard: ready=%b dout=%h rd=%b, need 1 ff 0", ddr3_ready, ddr3_dout, DDRAM_RD);
        end
        // A read of the same word must miss: the line was invalidated.
        bus_read(28'h0000040, 0, 1);
    endtask

    task automatic test_random();
        logic [27:0] a;
        for (int n = 0; n < 40; n++) begin
            a = 28'h0000100 + 28'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) drop_request();
            if ($urandom_range(0, 2) == 0)
                bus_write(a, 8'($urandom()), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else
                bus_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset            = 1'b1;
        ddr3_addr        = 28'h0;
        ddr3_rd          = 1'b0;
        ddr3_wr          = 1'b0;
        ddr3_din         = 8'h00;
        ddr3_request     = 1'b1;
        DDRAM_BUSY       = 1'b0;
        DDRAM_DOUT       = 64'h0;
        DDRAM_DOUT_READY = 1'b0;
        m_valid          = 1'b0;
        m_tag            = 25'h0;

        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_through();
        test_ownership();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
